// File: rtl/snac_pad_pkg.sv
// Shared types and constants for the SNAC Mega Drive pad reader: phase
// encoding, DB9 data-line bit positions per TH level, and the button record.
package snac_pad_pkg;

  localparam int NUM_PHASES = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_PH4,
    ST_PH5,
    ST_PH6,
    ST_PH7,
    ST_COMMIT
  } phase_e;

  // Data-line positions with TH high (first, second and third high phase)
  localparam int D_TH1_UP    = 0;
  localparam int D_TH1_DOWN  = 1;
  localparam int D_TH1_LEFT  = 2;
  localparam int D_TH1_RIGHT = 3;
  localparam int D_TH1_B     = 4;
  localparam int D_TH1_C     = 5;

  // Data-line positions with TH low; D2/D3 are forced low by any real pad
  localparam int D_TH0_ID2   = 2;
  localparam int D_TH0_ID3   = 3;
  localparam int D_TH0_A     = 4;
  localparam int D_TH0_START = 5;

  // Data-line positions in the fourth TH-high phase of a 6-button pad
  localparam int D_6B_Z      = 0;
  localparam int D_6B_Y      = 1;
  localparam int D_6B_X      = 2;
  localparam int D_6B_MODE   = 3;

  typedef struct packed {
    logic z;
    logic y;
    logic x;
    logic mode;
    logic start;
    logic c;
    logic b;
    logic a;
    logic right;
    logic left;
    logic down;
    logic up;
  } buttons_t;

  // Phase that follows a read phase; the last one hands over to COMMIT.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      ST_PH0:  return ST_PH1;
      ST_PH1:  return ST_PH2;
      ST_PH2:  return ST_PH3;
      ST_PH3:  return ST_PH4;
      ST_PH4:  return ST_PH5;
      ST_PH5:  return ST_PH6;
      ST_PH6:  return ST_PH7;
      ST_PH7:  return ST_COMMIT;
      default: return ST_IDLE;
    endcase
  endfunction

  // TH level driven during a given phase: low on odd read phases only.
  function automatic logic phase_th(input phase_e p);
    case (p)
      ST_PH1, ST_PH3, ST_PH5, ST_PH7: return 1'b0;
      default:                        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
module pad_sync #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  // Two-stage capture; data path carries no reset.
  always_ff @(posedge clk) begin
    meta_q <= d_in;
    sync_q <= meta_q;
  end

  assign d_out = sync_q;

endmodule

// File: rtl/snac_pad_reader.sv
// Console-side Mega Drive 6-button pad reader for a pad on the SNAC DB9 port.
// Walks TH through eight phases, samples the synchronized data lines at the
// end of each phase and publishes decoded active-high buttons atomically.
module snac_pad_reader
  import snac_pad_pkg::*;
#(
  parameter int STEP_CYCLES = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       POLL,
  input  logic [5:0] PAD_D,
  output logic       PAD_TH,
  output logic       PAD_TR,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  logic [5:0] raw_sync;
  logic [5:0] sd;

  phase_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       th_q, th_d;
  logic       done_q, done_d;
  buttons_t   btn_q, btn_d;
  logic       present_q, present_d;
  logic       six_btn_q, six_btn_d;

  buttons_t   cap_q, cap_d;
  logic       present_n_q, present_n_d;
  logic       six_n_q, six_n_d;

  pad_sync #(.DATA_W(6)) u_sync (
    .clk   (CLK),
    .d_in  (PAD_D),
    .d_out (raw_sync)
  );

  // Lines are active-low on the wire; flip so 1 means pressed/pulled low.
  assign sd = ~raw_sync;

  // Next-state, phase timing, sampling and commit decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    th_d        = th_q;
    done_d      = 1'b0;
    btn_d       = btn_q;
    present_d   = present_q;
    six_btn_d   = six_btn_q;
    cap_d       = cap_q;
    present_n_d = present_n_q;
    six_n_d     = six_n_q;

    case (state_q)
      ST_IDLE: begin
        th_d = 1'b1;
        if (POLL) begin
          state_d = ST_PH0;
          cnt_d   = 8'd0;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        btn_d   = cap_q;
        if (!six_n_q) begin
          btn_d.x    = 1'b0;
          btn_d.y    = 1'b0;
          btn_d.z    = 1'b0;
          btn_d.mode = 1'b0;
        end
        if (!present_n_q) begin
          btn_d = '0;
        end
        present_d = present_n_q;
        six_btn_d = present_n_q & six_n_q;
      end

      default: begin
        if (CE) begin
          if (cnt_q == STEP_LAST) begin
            cnt_d   = 8'd0;
            state_d = next_phase(state_q);
            th_d    = phase_th(next_phase(state_q));
            // Sample on the same edge that leaves the phase.
            case (state_q)
              ST_PH0: begin
                cap_d.up    = sd[D_TH1_UP];
                cap_d.down  = sd[D_TH1_DOWN];
                cap_d.left  = sd[D_TH1_LEFT];
                cap_d.right = sd[D_TH1_RIGHT];
                cap_d.b     = sd[D_TH1_B];
                cap_d.c     = sd[D_TH1_C];
              end
              ST_PH1: begin
                cap_d.a     = sd[D_TH0_A];
                cap_d.start = sd[D_TH0_START];
                present_n_d = sd[D_TH0_ID2] & sd[D_TH0_ID3];
              end
              ST_PH5: begin
                // A 6-button pad pulls D0..D3 all low on its third TH-low.
                six_n_d = &sd[3:0];
              end
              ST_PH6: begin
                cap_d.z    = sd[D_6B_Z];
                cap_d.y    = sd[D_6B_Y];
                cap_d.x    = sd[D_6B_X];
                cap_d.mode = sd[D_6B_MODE];
              end
              default: ;
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Control and published-result registers; reset returns to IDLE with TH high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      th_q      <= 1'b1;
      done_q    <= 1'b0;
      btn_q     <= '0;
      present_q <= 1'b0;
      six_btn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      th_q      <= th_d;
      done_q    <= done_d;
      btn_q     <= btn_d;
      present_q <= present_d;
      six_btn_q <= six_btn_d;
    end
  end

  // Per-poll capture registers; always rewritten before COMMIT reads them.
  always_ff @(posedge CLK) begin
    cap_q       <= cap_d;
    present_n_q <= present_n_d;
    six_n_q     <= six_n_d;
  end

  assign PAD_TH  = th_q;
  assign PAD_TR  = 1'b1;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign PRESENT = present_q;
  assign SIX_BTN = six_btn_q;

  assign P_UP    = btn_q.up;
  assign P_DOWN  = btn_q.down;
  assign P_LEFT  = btn_q.left;
  assign P_RIGHT = btn_q.right;
  assign P_A     = btn_q.a;
  assign P_B     = btn_q.b;
  assign P_C     = btn_q.c;
  assign P_START = btn_q.start;
  assign P_MODE  = btn_q.mode;
  assign P_X     = btn_q.x;
  assign P_Y     = btn_q.y;
  assign P_Z     = btn_q.z;

endmodule

// File: tb/tb_snac_pad_reader.sv
// Bench for snac_pad_reader: behavioural 3/6-button pad model, table of
// poll scenarios, and hand sequences for reset and back-to-back polling.
module tb_snac_pad_reader;

  localparam int STEP     = 20;
  localparam int PAD_IDLE = 100;

  logic       CLK = 1'b0;
  logic       RESET, CE, POLL;
  logic [5:0] PAD_D;
  logic       PAD_TH, PAD_TR;
  logic       P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START;
  logic       P_MODE, P_X, P_Y, P_Z;
  logic       PRESENT, SIX_BTN, BUSY, DONE;

  always #5 CLK = ~CLK;

  snac_pad_reader #(.STEP_CYCLES(STEP)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .POLL(POLL), .PAD_D(PAD_D),
    .PAD_TH(PAD_TH), .PAD_TR(PAD_TR),
    .P_UP(P_UP), .P_DOWN(P_DOWN), .P_LEFT(P_LEFT), .P_RIGHT(P_RIGHT),
    .P_A(P_A), .P_B(P_B), .P_C(P_C), .P_START(P_START),
    .P_MODE(P_MODE), .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z),
    .PRESENT(PRESENT), .SIX_BTN(SIX_BTN), .BUSY(BUSY), .DONE(DONE)
  );

  // held/btn_out bit order: 0 up,1 down,2 left,3 right,4 a,5 b,6 c,7 start,
  // 8 mode,9 x,10 y,11 z
  logic [11:0] btn_out;
  assign btn_out = {P_Z, P_Y, P_X, P_MODE, P_START, P_C, P_B, P_A,
                    P_RIGHT, P_LEFT, P_DOWN, P_UP};

  // ---------------- pad model ----------------
  logic        pad_on  = 1'b0;
  logic        pad_six = 1'b0;
  logic [11:0] held    = 12'h000;
  int          low_cnt = 0;
  int          idle_cnt = 0;
  int          tog_cnt = 0;
  int          done_cnt = 0;
  logic        th_prev = 1'b1;
  int          eff;
  logic [5:0]  pat;

  always @(posedge CLK) begin
    if (th_prev === 1'b1 && PAD_TH === 1'b0) low_cnt <= low_cnt + 1;
    else if (th_prev === 1'b1 && PAD_TH === 1'b1 && idle_cnt >= PAD_IDLE) low_cnt <= 0;
    idle_cnt <= (th_prev === 1'b1 && PAD_TH === 1'b1) ? idle_cnt + 1 : 0;
    if (th_prev !== PAD_TH) tog_cnt <= tog_cnt + 1;
    th_prev <= PAD_TH;
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  always_comb begin
    eff = low_cnt + ((th_prev === 1'b1 && PAD_TH === 1'b0) ? 1 : 0);
    pat = 6'b000000;
    if (!pad_on) pat = 6'b000000;
    else if (PAD_TH !== 1'b0) begin
      if (pad_six && eff == 3)
        pat = {held[6], held[5], held[8], held[9], held[10], held[11]};
      else
        pat = {held[6], held[5], held[3], held[2], held[1], held[0]};
    end else begin
      if (pad_six && eff == 3)      pat = {held[7], held[4], 4'b1111};
      else if (pad_six && eff == 4) pat = {held[7], held[4], 4'b0000};
      else                          pat = {held[7], held[4], 2'b11, held[1], held[0]};
    end
  end
  assign PAD_D = ~pat;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One poll with POLL pulsed on the accept edge; slow runs CE 1-of-3 and
  // fires extra POLL pulses while busy. lat = edges from accept to DONE.
  task automatic run_poll(input logic slow, output int lat, output logic timed_out);
    lat = 0;
    timed_out = 1'b1;
    @(negedge CLK);
    POLL = 1'b1;
    CE   = slow ? 1'b0 : 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge CLK);
      #1;
      POLL = slow && (cyc == 50 || cyc == 200 || cyc == 300);
      if (cyc == 1) chk("busy_after_accept", BUSY, 1);
      if (DONE === 1'b1) begin
        lat = cyc;
        timed_out = 1'b0;
        break;
      end
      CE = slow ? (cyc % 3 == 0) : 1'b1;
    end
    POLL = 1'b0;
    CE   = 1'b1;
  endtask

  typedef struct {
    logic        on;
    logic        six;
    logic [11:0] held;
    logic        slow;
    logic [11:0] ebtn;
    logic        epres;
    logic        esix;
    int          elat;
  } vec_t;

  vec_t vecs [7];
  int   lat, t0, d0;
  logic to;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 12'h018, 1'b0, 12'h018, 1'b1, 1'b0, 162};
    vecs[1] = '{1'b1, 1'b1, 12'h380, 1'b0, 12'h380, 1'b1, 1'b1, 162};
    vecs[2] = '{1'b0, 1'b0, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b0, 162};
    vecs[3] = '{1'b1, 1'b0, 12'hFFE, 1'b0, 12'h0FE, 1'b1, 1'b0, 162};
    vecs[4] = '{1'b1, 1'b1, 12'hC61, 1'b0, 12'hC61, 1'b1, 1'b1, 162};
    vecs[5] = '{1'b1, 1'b1, 12'h012, 1'b1, 12'h012, 1'b1, 1'b1, 482};
    vecs[6] = '{1'b1, 1'b1, 12'hFFF, 1'b0, 12'hFFF, 1'b1, 1'b1, 162};

    // Reset, with POLL asserted throughout to confirm reset wins
    RESET = 1'b1;
    POLL  = 1'b1;
    CE    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_th", PAD_TH, 1);
    chk("rst_tr", PAD_TR, 1);
    chk("rst_btn", btn_out, 0);
    chk("rst_present", PRESENT, 0);
    chk("rst_six", SIX_BTN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    POLL  = 1'b0;

    // Table of poll scenarios
    for (int i = 0; i < 7; i++) begin
      pad_on  = vecs[i].on;
      pad_six = vecs[i].six;
      held    = vecs[i].held;
      repeat (PAD_IDLE + 20) @(posedge CLK);
      #1;
      t0 = tog_cnt;
      d0 = done_cnt;
      run_poll(vecs[i].slow, lat, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_buttons", i), btn_out, vecs[i].ebtn);
      chk($sformatf("v%0d_present", i), PRESENT, vecs[i].epres);
      chk($sformatf("v%0d_six", i), SIX_BTN, vecs[i].esix);
      chk($sformatf("v%0d_busy_at_done", i), BUSY, 0);
      chk($sformatf("v%0d_th_toggles", i), tog_cnt - t0, 8);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_done_width", i), DONE, 0);
      repeat (200) @(posedge CLK);
      #1;
      chk($sformatf("v%0d_one_done", i), done_cnt - d0, 1);
    end

    // Reset during PH4: no DONE, outputs cleared, TH high
    pad_on = 1'b1; pad_six = 1'b1; held = 12'h0A5;
    repeat (PAD_IDLE + 20) @(posedge CLK);
    #1;
    d0 = done_cnt;
    @(negedge CLK);
    POLL = 1'b1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(posedge CLK);
      #1;
      POLL = 1'b0;
    end
    chk("ph4_busy", BUSY, 1);
    chk("ph4_th", PAD_TH, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("ph4rst_th", PAD_TH, 1);
    chk("ph4rst_busy", BUSY, 0);
    chk("ph4rst_done", DONE, 0);
    chk("ph4rst_btn", btn_out, 0);
    chk("ph4rst_present", PRESENT, 0);
    chk("ph4rst_six", SIX_BTN, 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (200) @(posedge CLK);
    #1;
    chk("ph4rst_no_done", done_cnt - d0, 0);

    // Fresh poll after the pad has idled long enough to clear its counter
    run_poll(1'b0, lat, to);
    chk("fresh_latency", lat, 162);
    chk("fresh_buttons", btn_out, 12'h0A5);
    chk("fresh_present", PRESENT, 1);
    chk("fresh_six", SIX_BTN, 1);
    repeat (PAD_IDLE + 20) @(posedge CLK);

    // POLL held high: back-to-back polls with one IDLE cycle, then a reset
    // in PH3 (TH low) that coincides with POLL still high
    held = 12'h100;
    @(negedge CLK);
    POLL = 1'b1;
    lat = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge CLK);
      #1;
      if (DONE === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    chk("b2b_latency", lat, 162);
    chk("b2b_busy_gap", BUSY, 0);
    chk("b2b_mode", btn_out, 12'h100);
    @(posedge CLK);
    #1;
    chk("b2b_reaccept", BUSY, 1);
    repeat (69) @(posedge CLK);
    #1;
    chk("ph3_th", PAD_TH, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("ph3rst_th", PAD_TH, 1);
    chk("ph3rst_busy", BUSY, 0);
    chk("ph3rst_btn", btn_out, 0);
    @(posedge CLK);
    #1;
    chk("rst_beats_poll", BUSY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    POLL  = 1'b0;
    repeat (5) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
